// File: rtl/branch_update_queue_pkg.sv
// branch_update_queue_pkg: shared widths and the ROB-to-predictor update packet types
package branch_update_queue_pkg;
  localparam int N = 2;
  localparam int ADDR = 32;
  localparam int BUQ_DEPTH = 8;
  localparam int OW = $clog2(N + 1);
  typedef struct packed {
    logic valid;
    logic [ADDR-1:0] pc;
    logic resolve_taken;
    logic [ADDR-1:0] resolve_target;
  } rob_if_entry_t;
  typedef struct packed {
    rob_if_entry_t [N-1:0] entries;
  } rob_if_packet_t;
endpackage

// File: rtl/branch_update_queue_compactor.sv
// branch_update_queue_compactor: prefix-sum of retiring branches into write offsets and an accept mask
// Ports: retire_valid/retire_is_branch select slots; space is the pre-pop room in the queue;
// offset[i] is slot i's position among enqueued slots; accept marks slots that fit;
// enq_cnt counts all enqueue requests, acc_cnt only the accepted ones.
module branch_update_queue_compactor
  import branch_update_queue_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [N-1:0]          retire_valid,
  input  logic [N-1:0]          retire_is_branch,
  input  logic [CW-1:0]         space,
  output logic [N-1:0][OW-1:0]  offset,
  output logic [N-1:0]          accept,
  output logic [OW-1:0]         enq_cnt,
  output logic [CW-1:0]         acc_cnt
);
  logic [N-1:0] enq;
  assign enq = retire_valid & retire_is_branch;
  // Offsets grow in slot order, so a shortage of space drops only the youngest slots.
  always_comb begin
    offset = '0;
    accept = '0;
    enq_cnt = '0;
    acc_cnt = '0;
    for (int i = 0; i < N; i++) begin
      offset[i] = enq_cnt;
      accept[i] = enq[i] && (CW'(enq_cnt) < space);
      enq_cnt = enq_cnt + OW'(enq[i]);
      acc_cnt = acc_cnt + CW'(accept[i]);
    end
  end
endmodule

// File: rtl/branch_update_queue.sv
// branch_update_queue: circular FIFO of resolved branches drained oldest-first to the predictors
// Ports: clock/reset_n (async active-low); retire_* are the ROB retirement slots;
// hold stalls draining; rob_if_packet presents up to DRAIN_W oldest entries;
// free_slots is the registered credit for the ROB; overflow_err is sticky until reset.
module branch_update_queue
  import branch_update_queue_pkg::*;
#(
  parameter int DEPTH = BUQ_DEPTH,
  parameter int DRAIN_W = N
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N-1:0]                  retire_valid,
  input  logic [N-1:0]                  retire_is_branch,
  input  logic [N-1:0][ADDR-1:0]        retire_pc,
  input  logic [N-1:0]                  retire_taken,
  input  logic [N-1:0][ADDR-1:0]        retire_target,
  input  logic                          hold,
  output rob_if_packet_t                rob_if_packet,
  output logic [$clog2(DEPTH+1)-1:0]    free_slots,
  output logic                          overflow_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, free_q, free_d;
  logic [CW-1:0] space, avail, pop, acc_cnt;
  logic ovf_q, ovf_d;
  rob_if_entry_t mem_q [DEPTH];
  rob_if_entry_t mem_d [DEPTH];
  logic [N-1:0][OW-1:0] offset;
  logic [N-1:0] accept;
  logic [OW-1:0] enq_cnt;
  // Space is measured before this cycle's pops: freed slots are not reused until the next cycle.
  assign space = CW'(DEPTH) - count_q;
  branch_update_queue_compactor #(.CW(CW)) u_compactor (
    .retire_valid     (retire_valid),
    .retire_is_branch (retire_is_branch),
    .space            (space),
    .offset           (offset),
    .accept           (accept),
    .enq_cnt          (enq_cnt),
    .acc_cnt          (acc_cnt)
  );
  always_comb begin
    avail = count_q < CW'(DRAIN_W) ? count_q : CW'(DRAIN_W);
    pop = hold ? '0 : avail;
    count_d = count_q - pop + acc_cnt;
    free_d = CW'(DEPTH) - count_d;
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(acc_cnt);
    ovf_d = ovf_q | (CW'(enq_cnt) > space);
    mem_d = mem_q;
    for (int i = 0; i < N; i++)
      if (accept[i])
        mem_d[tail_q + PW'(offset[i])] = '{valid: 1'b1, pc: retire_pc[i],
                                           resolve_taken: retire_taken[i],
                                           resolve_target: retire_target[i]};
    // Presentation reads only registered state, so a new entry appears the cycle after its write.
    rob_if_packet = '0;
    for (int k = 0; k < N; k++)
      if (CW'(k) < avail) rob_if_packet.entries[k] = mem_q[head_q + PW'(k)];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      free_q <= CW'(DEPTH);
      ovf_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      free_q <= free_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clock) mem_q <= mem_d;
  assign free_slots = free_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed table-driven check of the branch update queue
module tb_branch_update_queue;
  import branch_update_queue_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] rv = '0, rb = '0, rt = '0;
  logic [1:0][31:0] rp = '0, rtg = '0;
  logic hold = 1'b0;
  rob_if_packet_t pkt;
  logic [3:0] free;
  logic ovf;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  branch_update_queue dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .retire_valid     (rv),
    .retire_is_branch (rb),
    .retire_pc        (rp),
    .retire_taken     (rt),
    .retire_target    (rtg),
    .hold             (hold),
    .rob_if_packet    (pkt),
    .free_slots       (free),
    .overflow_err     (ovf)
  );
  typedef struct {
    logic [1:0] v, br, tk;
    logic [31:0] p0, p1, t0, t1;
    logic h;
    logic [65:0] e0, e1;
    logic [3:0] free;
    logic ovf;
  } vec_t;
  vec_t vecs[21];
  function automatic logic [31:0] tg(input logic [31:0] p);
    return p + 32'h1000;
  endfunction
  function automatic logic [65:0] en(input logic [31:0] p, input logic t, input logic [31:0] g);
    return {1'b1, p, t, g};
  endfunction
  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic [1:0] br, input logic [1:0] tk,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] t0, input logic [31:0] t1, input logic h);
    @(negedge clock);
    rv = v; rb = br; rt = tk; rp[0] = p0; rp[1] = p1; rtg[0] = t0; rtg[1] = t1; hold = h;
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask
  task automatic push2(input logic [31:0] p, input logic h);
    drive(2'b11, 2'b11, 2'b01, p, p + 4, tg(p), tg(p + 4), h);
  endtask
  initial begin
    vecs[0]  = '{2'b10, 2'b10, 2'b10, 32'h0, 32'h100, 32'h0, 32'h200, 1'b0, en(32'h100, 1'b1, 32'h200), 66'h0, 4'd7, 1'b0};
    vecs[1]  = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 66'h0, 66'h0, 4'd8, 1'b0};
    vecs[2]  = '{2'b11, 2'b11, 2'b01, 32'h10, 32'h14, tg(32'h10), tg(32'h14), 1'b1, en(32'h10, 1'b1, tg(32'h10)), en(32'h14, 1'b0, tg(32'h14)), 4'd6, 1'b0};
    vecs[3]  = '{2'b11, 2'b11, 2'b01, 32'h18, 32'h1C, tg(32'h18), tg(32'h1C), 1'b1, en(32'h10, 1'b1, tg(32'h10)), en(32'h14, 1'b0, tg(32'h14)), 4'd4, 1'b0};
    vecs[4]  = '{2'b11, 2'b11, 2'b01, 32'h20, 32'h24, tg(32'h20), tg(32'h24), 1'b1, en(32'h10, 1'b1, tg(32'h10)), en(32'h14, 1'b0, tg(32'h14)), 4'd2, 1'b0};
    vecs[5]  = '{2'b11, 2'b11, 2'b01, 32'h28, 32'h2C, tg(32'h28), tg(32'h2C), 1'b1, en(32'h10, 1'b1, tg(32'h10)), en(32'h14, 1'b0, tg(32'h14)), 4'd0, 1'b0};
    vecs[6]  = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, en(32'h18, 1'b1, tg(32'h18)), en(32'h1C, 1'b0, tg(32'h1C)), 4'd2, 1'b0};
    vecs[7]  = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, en(32'h20, 1'b1, tg(32'h20)), en(32'h24, 1'b0, tg(32'h24)), 4'd4, 1'b0};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, en(32'h28, 1'b1, tg(32'h28)), en(32'h2C, 1'b0, tg(32'h2C)), 4'd6, 1'b0};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 66'h0, 66'h0, 4'd8, 1'b0};
    vecs[10] = '{2'b11, 2'b11, 2'b01, 32'h50, 32'h54, tg(32'h50), tg(32'h54), 1'b1, en(32'h50, 1'b1, tg(32'h50)), en(32'h54, 1'b0, tg(32'h54)), 4'd6, 1'b0};
    vecs[11] = '{2'b11, 2'b11, 2'b01, 32'h58, 32'h5C, tg(32'h58), tg(32'h5C), 1'b1, en(32'h50, 1'b1, tg(32'h50)), en(32'h54, 1'b0, tg(32'h54)), 4'd4, 1'b0};
    vecs[12] = '{2'b11, 2'b11, 2'b01, 32'h60, 32'h64, tg(32'h60), tg(32'h64), 1'b1, en(32'h50, 1'b1, tg(32'h50)), en(32'h54, 1'b0, tg(32'h54)), 4'd2, 1'b0};
    vecs[13] = '{2'b01, 2'b01, 2'b01, 32'h68, 32'h0, tg(32'h68), 32'h0, 1'b1, en(32'h50, 1'b1, tg(32'h50)), en(32'h54, 1'b0, tg(32'h54)), 4'd1, 1'b0};
    vecs[14] = '{2'b11, 2'b11, 2'b01, 32'h40, 32'h44, tg(32'h40), tg(32'h44), 1'b1, en(32'h50, 1'b1, tg(32'h50)), en(32'h54, 1'b0, tg(32'h54)), 4'd0, 1'b1};
    vecs[15] = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, en(32'h58, 1'b1, tg(32'h58)), en(32'h5C, 1'b0, tg(32'h5C)), 4'd2, 1'b1};
    vecs[16] = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, en(32'h60, 1'b1, tg(32'h60)), en(32'h64, 1'b0, tg(32'h64)), 4'd4, 1'b1};
    vecs[17] = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, en(32'h68, 1'b1, tg(32'h68)), en(32'h40, 1'b1, tg(32'h40)), 4'd6, 1'b1};
    vecs[18] = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 66'h0, 66'h0, 4'd8, 1'b1};
    vecs[19] = '{2'b11, 2'b10, 2'b00, 32'h999, 32'h300, 32'h0, 32'h304, 1'b0, en(32'h300, 1'b0, 32'h304), 66'h0, 4'd7, 1'b1};
    vecs[20] = '{2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 66'h0, 66'h0, 4'd8, 1'b1};
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("reset e0", pkt.entries[0], 66'h0);
    chk("reset e1", pkt.entries[1], 66'h0);
    chk("reset free", 66'(free), 66'd8);
    chk("reset ovf", 66'(ovf), 66'd0);
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].v, vecs[i].br, vecs[i].tk, vecs[i].p0, vecs[i].p1, vecs[i].t0, vecs[i].t1, vecs[i].h);
      chk($sformatf("vec%0d e0", i), pkt.entries[0], vecs[i].e0);
      chk($sformatf("vec%0d e1", i), pkt.entries[1], vecs[i].e1);
      chk($sformatf("vec%0d free", i), 66'(free), 66'(vecs[i].free));
      chk($sformatf("vec%0d ovf", i), 66'(ovf), 66'(vecs[i].ovf));
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("ovf cleared", 66'(ovf), 66'd0);
    @(negedge clock);
    reset_n = 1'b1;
    push2(32'h1000, 1'b0);
    chk("wrap prime e0", pkt.entries[0], en(32'h1000, 1'b1, tg(32'h1000)));
    chk("wrap prime free", 66'(free), 66'd6);
    for (int j = 1; j <= 20; j++) begin
      logic [31:0] p;
      p = 32'h1000 + 32'(8 * j);
      push2(p, 1'b0);
      chk($sformatf("wrap%0d e0", j), pkt.entries[0], en(p, 1'b1, tg(p)));
      chk($sformatf("wrap%0d e1", j), pkt.entries[1], en(p + 4, 1'b0, tg(p + 4)));
      chk($sformatf("wrap%0d free", j), 66'(free), 66'd6);
    end
    idle();
    chk("wrap drained e0", pkt.entries[0], 66'h0);
    chk("wrap drained free", 66'(free), 66'd8);
    push2(32'h500, 1'b1);
    push2(32'h508, 1'b1);
    drive(2'b01, 2'b01, 2'b01, 32'h510, 32'h0, tg(32'h510), 32'h0, 1'b1);
    chk("pre-reset free", 66'(free), 66'd3);
    chk("pre-reset e0", pkt.entries[0], en(32'h500, 1'b1, tg(32'h500)));
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async free", 66'(free), 66'd8);
    chk("async e0", pkt.entries[0], 66'h0);
    chk("async e1", pkt.entries[1], 66'h0);
    @(negedge clock);
    rv = '0; rb = '0; hold = 1'b0;
    reset_n = 1'b1;
    idle();
    chk("post-reset e0", pkt.entries[0], 66'h0);
    chk("post-reset free", 66'(free), 66'd8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- Commit-side producer of ROB_IF_PACKET, the resolution-update packet that the fetch-stage branch predictors (BTB/BHT/PHT) consume.
- Captures resolved branches as the ROB retires them, compacts them into a circular FIFO, and drains them oldest-first to the predictor, up to `N per cycle.
- Issues a credit count back to the ROB so retirement never overruns the queue.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= `N.
- DRAIN_W, `N, max entries presented per cycle; 1..`N.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- retire_valid  in  [`N]  ROB slot i retires this cycle.
- retire_is_branch  in  [`N]  slot i is a conditional branch or jump.
- retire_pc  in  [`N] x ADDR  PC of slot i.
- retire_taken  in  [`N]  resolved direction of slot i.
- retire_target  in  [`N] x ADDR  resolved target of slot i.
- hold  in  1  predictor update port busy; no drain this cycle.
- rob_if_packet  out  ROB_IF_PACKET  entries[0..`N-1]: valid, PC, resolve_taken, resolve_target.
- free_slots  out  $clog2(DEPTH+1)  credits for the ROB, registered.
- overflow_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset, async on reset_n=0:
  - head, tail and count all 0.
  - free_slots=DEPTH, overflow_err=0.
  - All rob_if_packet entries invalid.
  - Storage contents are don't-care.
- Enqueue set: slots with retire_valid & retire_is_branch.
  - Compacted in ascending slot order (slot 0 oldest) to tail, tail+1, …
  - Indices wrap mod DEPTH.
- Presentation:
  - rob_if_packet.entries[k] = queue[head+k] for k < min(count, DRAIN_W).
  - Entries k >= min(count, DRAIN_W) are all-zero and invalid.
  - Driven purely from registered state: an entry written at edge t is visible in the cycle after t, never same-cycle.
- Drain, at each edge: pop = (hold ? 0 : min(count, DRAIN_W)).
  - While hold=1 the packet stays fully valid.
  - The predictor qualifies updates with hold externally; this block guarantees exactly-once delivery only on non-hold cycles.
- Count update: count' = count − pop + enq_accepted.
  - Pops and pushes in the same cycle are both honoured.
  - Freed slots are not reusable by that cycle's pushes: acceptance is limited by pre-pop space, DEPTH − count.
- Credit: free_slots' = DEPTH − count'.
  - The ROB must retire no more branches in a cycle than the current free_slots.
- Overflow:
  - If the enqueue set exceeds DEPTH − count, the oldest entries that fit are accepted and the youngest are dropped.
  - overflow_err is set and stays 1 until reset.
- Full/empty:
  - count==DEPTH: free_slots=0.
  - count==0: no valid entries presented.
  - head and tail wrap independently; count disambiguates full from empty.
- Non-branch slots and retire_valid=0 slots are ignored. Holes between branch slots are squeezed out by compaction.
- No squash input: retired branches are architectural and always delivered.
- Reset mid-operation: all queued entries are discarded immediately. The next cycle shows an empty packet.

Decomposition:
- sys_defs.svh (shared):
  - ROB_IF_ENTRY / ROB_IF_PACKET, already shared with the predictors.
  - New constant `BUQ_DEPTH, the default for DEPTH.
- Sub-module buq_compactor (combinational):
  - Prefix-sum over retire_valid & retire_is_branch.
  - Yields each slot's write offset and the enqueue count.
  - Also produces the accepted mask (offset < space).

Test Plan (`N=2, DEPTH=8, DRAIN_W=2):
1. Reset, then one branch in slot 1 (PC 0x100, taken, target 0x200), hold=0 → next cycle entries[0]={1,0x100,1,0x200}, entries[1] invalid, free_slots 7. The following cycle the packet is empty and free_slots is 8.
2. hold=1, retire 2 branches/cycle for 4 cycles (PCs 0x10..0x2C) → free_slots 6,4,2,0. Packet stays {0x10,0x14}. After hold=0, the packet order is 0x10/0x14, 0x18/0x1C, …, 0x28/0x2C over 4 cycles.
3. count=7 with hold=1, retire 2 branches (0x40, 0x44) → 0x40 accepted, 0x44 dropped, overflow_err=1 and stays 1 until reset_n asserts.
4. Drive head/tail past index 7 with continuous 2-in/2-out traffic for 20 cycles → FIFO order is preserved across the wrap and free_slots stays constant at 6.
5. Slot 0 non-branch and slot 1 branch (0x300, not taken, target 0x304), count=0 → single entry in entries[0], enqueue count 1.
6. Assert reset_n low asynchronously mid-cycle with count=5 → outputs clear without waiting for a clock edge: free_slots 8, no valid entries.
